frac_decimal_stream: RTL

Converts one unsigned binary fixed-point value (small integer part, long binary fraction) into a stream of decimal digits, most significant first: one integer digit, then a fixed count of fractional digits. It sits between the e-series accumulator and the digit capture/display logic. It consumes the accumulator's wide result and produces one 4-bit BCD digit per accepted handshake, followed by a completion pulse.

---
 rtl/frac_decimal_stream.sv | 94 +++++++++
 1 files changed

// File: rtl/frac_decimal_stream.sv
// Binary fixed-point to decimal digit streamer: one integer digit,
// then NDIG fractional digits produced by repeated multiply-by-ten.
module frac_decimal_stream #(
    parameter int W        = 400,
    parameter int INT_BITS = 4,
    parameter int NDIG     = 120
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] binary,
    input  logic         ready,
    output logic [3:0]   digit,
    output logic         valid,
    output logic         done,
    output logic         busy,
    output logic         err
);
    localparam int FB = W - INT_BITS;
    localparam logic [7:0] LAST = 8'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INT,
        S_FRAC,
        S_FIN
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [INT_BITS-1:0] ip;
    logic [FB-1:0]       fr;
    logic [7:0]          cnt;
    logic [FB+3:0]       p;
    logic [INT_BITS+3:0] ip_in;
    logic                ovf;

    // fr*10 as two shifts; the top nibble is the next decimal digit
    assign p     = ({4'b0, fr} << 3) + ({4'b0, fr} << 1);
    assign ip_in = {4'b0, binary[W-1 -: INT_BITS]};
    assign ovf   = ip_in > (INT_BITS + 4)'(9);

    always_comb begin
        state_n = state;
        valid   = 1'b0;
        done    = 1'b0;
        busy    = 1'b0;
        digit   = 4'h0;
        unique case (state)
            S_IDLE: begin
                if (start) state_n = S_INT;
            end
            S_INT: begin
                valid = 1'b1;
                busy  = 1'b1;
                digit = err ? 4'hF : 4'(ip);
                if (ready) state_n = S_FRAC;
            end
            S_FRAC: begin
                valid = 1'b1;
                busy  = 1'b1;
                digit = p[FB+3:FB];
                if (ready && cnt == LAST) state_n = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ip    <= '0;
            fr    <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && start) begin
                ip  <= binary[W-1 -: INT_BITS];
                fr  <= binary[FB-1:0];
                cnt <= '0;
                err <= ovf;
            end
            if (state == S_FRAC && ready) begin
                fr  <= p[FB-1:0];
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule
